// File: rtl/iic_slave_regs.sv
// I2C target with a 2**ADDR_WIDTH byte register file: ACKs address/register/data writes,
// serves auto-incrementing reads, and exposes a one-cycle write strobe plus a local read port.
`timescale 1ns/1ps
module iic_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1001100,
    parameter int         ADDR_WIDTH = 6,
    parameter int         FILTER_LEN = 3
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  SCL_in,
    input  logic                  SDA_in,
    output logic                  SDA_drive_low,
    output logic                  Busy,
    output logic                  Wr_strobe,
    output logic [ADDR_WIDTH-1:0] Wr_addr,
    output logic [7:0]            Wr_data,
    input  logic [ADDR_WIDTH-1:0] Rd_addr,
    output logic [7:0]            Rd_data,
    output logic [3:0]            dbg_state_o
);
    localparam int FCW = $clog2(FILTER_LEN + 1);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_REG       = 4'd3;
    localparam logic [3:0] ST_REG_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;

    // Index 0 carries SCL, index 1 carries SDA through synchroniser and filter.
    logic [1:0]     s1_q, s2_q, filt_q, prev_q;
    logic [FCW-1:0] fcnt_q [2];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_q      <= 2'b11;
            s2_q      <= 2'b11;
            filt_q    <= 2'b11;
            prev_q    <= 2'b11;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
        end else begin
            s1_q   <= {SDA_in, SCL_in};
            s2_q   <= s1_q;
            prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= s2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + FCW'(1);
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det, sda_bit;
    assign scl_rise  = filt_q[0] & ~prev_q[0];
    assign scl_fall  = ~filt_q[0] & prev_q[0];
    assign start_det = filt_q[0] & prev_q[0] & prev_q[1] & ~filt_q[1];
    assign stop_det  = filt_q[0] & prev_q[0] & ~prev_q[1] & filt_q[1];
    assign sda_bit   = filt_q[1];

    logic [3:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [7:0]            shift_q, shift_d, rx_byte;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  drv_q, drv_d, rw_q, rw_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic                  mem_we;
    logic [7:0]            mem_q [2**ADDR_WIDTH];
    logic [7:0]            rd_data_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        drv_d       = drv_q;
        rw_d        = rw_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        mem_we      = 1'b0;
        rx_byte     = {shift_q[6:0], sda_bit};
        if (stop_det) begin
            state_d = ST_IDLE;
            drv_d   = 1'b0;
        end else if (start_det) begin
            state_d = ST_ADDR;
            cnt_d   = 4'd0;
            drv_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_REG: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (state_q == ST_REG) begin
                            ptr_d   = shift_q[ADDR_WIDTH-1:0];
                            drv_d   = 1'b1;
                            state_d = ST_REG_ACK;
                        end else if (shift_q[7:1] == SLAVE_ADDR) begin
                            rw_d    = shift_q[0];
                            drv_d   = 1'b1;
                            state_d = ST_ADDR_ACK;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                // The fall ending the ACK bit also presents the first read bit.
                ST_ADDR_ACK, ST_RDATA_ACK: begin
                    if (scl_rise && state_q == ST_RDATA_ACK && sda_bit) begin
                        state_d = ST_IDLE;
                    end else if (scl_fall) begin
                        cnt_d = 4'd0;
                        if (state_q == ST_RDATA_ACK || rw_q) begin
                            state_d = ST_RDATA;
                            shift_d = mem_q[ptr_q];
                            drv_d   = ~mem_q[ptr_q][7];
                        end else begin
                            state_d = ST_REG;
                            drv_d   = 1'b0;
                        end
                    end
                end
                ST_REG_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        drv_d   = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            mem_we      = 1'b1;
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = ptr_q;
                            wr_data_d   = rx_byte;
                            ptr_d       = ptr_q + ADDR_WIDTH'(1);
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        drv_d   = 1'b1;
                        state_d = ST_WDATA_ACK;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            drv_d   = 1'b0;
                            ptr_d   = ptr_q + ADDR_WIDTH'(1);
                            state_d = ST_RDATA_ACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            drv_d   = ~shift_q[6];
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    drv_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            shift_q     <= 8'h00;
            ptr_q       <= '0;
            drv_q       <= 1'b0;
            rw_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            drv_q       <= drv_d;
            rw_q        <= rw_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Rd_data samples the array before this cycle's write lands, so a same-cycle hit reads old data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 2**ADDR_WIDTH; i++) mem_q[i] <= 8'h00;
            rd_data_q <= 8'h00;
        end else begin
            if (mem_we) mem_q[ptr_q] <= rx_byte;
            rd_data_q <= mem_q[Rd_addr];
        end
    end

    assign SDA_drive_low = drv_q;
    assign Busy          = (state_q != ST_IDLE) && (state_q != ST_ADDR);
    assign Wr_strobe     = wr_strobe_q;
    assign Wr_addr       = wr_addr_q;
    assign Wr_data       = wr_data_q;
    assign Rd_data       = rd_data_q;
    assign dbg_state_o   = state_q;
endmodule
